// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// UART transmit channel with a small transmit FIFO. The producer pushes words
// through a valid/ready handshake. A frame FSM pops one word at a time and
// serialises it onto the TX pin as a UART frame:
//   start(0), DATA_BITS data bits LSB first, optional parity, 1 or 2 stop(1).
// Each bit lasts CLKS_PER_BIT cycles of clock_out.
//
// Handshake: a word is accepted on a rising edge of clock_out when
// valid_tx_in && ready_tx_out. ready_tx_out depends only on the registered
// FIFO count, so it never depends on valid_tx_in. A push while full is
// dropped. There is no bypass path: a word is written into the FIFO first and
// can be popped on a later edge at the earliest.
//
// Ports:
//   clock_out       in   system clock, rising edge
//   nreset          in   asynchronous active-low reset
//   valid_tx_in     in   producer word valid
//   data_tx_in      in   [DATA_BITS-1:0] producer word
//   ready_tx_out    out  FIFO not full
//   parity_mode_in  in   [1:0] 00 none, 01 even, 10 odd, 11 none
//   stop2_in        in   0 = one stop bit, 1 = two stop bits
//   sdata_tx_out    out  serial line, registered, idle high
//   busy_tx_out     out  frame in progress (FSM not idle)
//   fifo_count_out  out  [$clog2(FIFO_DEPTH):0] words buffered
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int CLOCK_HZ     = 50_000_000,
    parameter int BAUDRATE     = 115200,
    parameter int CLKS_PER_BIT = CLOCK_HZ / BAUDRATE
) (
    input  logic                          clock_out,
    input  logic                          nreset,
    input  logic                          valid_tx_in,
    input  logic [DATA_BITS-1:0]          data_tx_in,
    output logic                          ready_tx_out,
    input  logic [1:0]                    parity_mode_in,
    input  logic                          stop2_in,
    output logic                          sdata_tx_out,
    output logic                          busy_tx_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_BITS);

    localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // -------------------------------------------------------------------------
    // FIFO storage and pointers
    // -------------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     fifo_count;
    logic [DATA_BITS-1:0] head;
    logic                 push;
    logic                 pop;

    assign ready_tx_out   = (fifo_count != FULL_COUNT);
    assign push           = valid_tx_in && ready_tx_out;
    assign head           = mem[rd_ptr];
    assign fifo_count_out = fifo_count;

    // Storage has no reset: contents are only ever read behind a valid count.
    always_ff @(posedge clock_out) begin
        if (push) begin
            mem[wr_ptr] <= data_tx_in;
        end
    end

    always_ff @(posedge clock_out or negedge nreset) begin
        if (!nreset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Simultaneous push and pop leaves the count unchanged.
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Frame FSM: state register and datapath registers
    // -------------------------------------------------------------------------
    state_t               state,     state_n;
    logic [BAUD_W-1:0]    baud_cnt,  baud_n;
    logic [BIT_W-1:0]     bit_cnt,   bit_n;
    logic [DATA_BITS-1:0] shift_reg, shift_n;
    logic                 par_en,    par_en_n;
    logic                 par_bit,   par_bit_n;
    logic                 stop2,     stop2_n;
    logic                 sdata,     sdata_n;

    always_ff @(posedge clock_out or negedge nreset) begin
        if (!nreset) begin
            state     <= ST_IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            par_en    <= 1'b0;
            par_bit   <= 1'b0;
            stop2     <= 1'b0;
            sdata     <= 1'b1;
        end else begin
            state     <= state_n;
            baud_cnt  <= baud_n;
            bit_cnt   <= bit_n;
            shift_reg <= shift_n;
            par_en    <= par_en_n;
            par_bit   <= par_bit_n;
            stop2     <= stop2_n;
            sdata     <= sdata_n;
        end
    end

    assign sdata_tx_out = sdata;
    assign busy_tx_out  = (state != ST_IDLE);

    // -------------------------------------------------------------------------
    // Next-state and next-output logic. sdata_n is the value the line takes
    // for the bit that starts on the coming edge, so the line is registered
    // and changes exactly on bit boundaries.
    // -------------------------------------------------------------------------
    always_comb begin
        state_n   = state;
        baud_n    = baud_cnt;
        bit_n     = bit_cnt;
        shift_n   = shift_reg;
        par_en_n  = par_en;
        par_bit_n = par_bit;
        stop2_n   = stop2;
        sdata_n   = sdata;
        pop       = 1'b0;

        case (state)
            ST_IDLE: begin
                sdata_n = 1'b1;
                baud_n  = '0;
                bit_n   = '0;
                if (fifo_count != '0) begin
                    // Pop the head word and freeze the frame configuration;
                    // the start bit goes onto the line on this same edge.
                    pop       = 1'b1;
                    shift_n   = head;
                    par_en_n  = (parity_mode_in == 2'b01) || (parity_mode_in == 2'b10);
                    par_bit_n = (^head) ^ (parity_mode_in == 2'b10);
                    stop2_n   = stop2_in;
                    state_n   = ST_START;
                    sdata_n   = 1'b0;
                end
            end

            ST_START: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    state_n = ST_DATA;
                    sdata_n = shift_reg[0];
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end

            ST_DATA: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_n = '0;
                    if (bit_cnt == BIT_LAST) begin
                        bit_n = '0;
                        if (par_en) begin
                            state_n = ST_PARITY;
                            sdata_n = par_bit;
                        end else begin
                            state_n = ST_STOP;
                            sdata_n = 1'b1;
                        end
                    end else begin
                        bit_n   = bit_cnt + 1'b1;
                        shift_n = shift_reg >> 1;
                        sdata_n = shift_reg[1];
                    end
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end

            ST_PARITY: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    state_n = ST_STOP;
                    sdata_n = 1'b1;
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end

            ST_STOP: begin
                sdata_n = 1'b1;
                if (baud_cnt == BAUD_LAST) begin
                    baud_n = '0;
                    // bit_cnt counts stop bits already sent in this state.
                    if (stop2 && (bit_cnt == '0)) begin
                        bit_n = BIT_W'(1);
                    end else begin
                        bit_n   = '0;
                        state_n = ST_IDLE;
                    end
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end

            default: begin
                state_n = ST_IDLE;
                sdata_n = 1'b1;
                baud_n  = '0;
                bit_n   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Two instances share clock and reset: an 8-bit channel checked every cycle
// against a queue-based frame model, and a 5-bit channel checked by hand.
// Handshake: a word is taken on a rising edge when valid && ready; ready
// reflects only the buffered count. Inputs change just after falling edges,
// outputs are sampled on falling edges.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    // ---------------- clock / reset ----------------
    logic clk    = 1'b0;
    logic nreset = 1'b0;
    always #5 clk = ~clk;

    // ---------------- 8-bit channel ----------------
    logic       valid8  = 1'b0;
    logic [7:0] data8   = '0;
    logic [1:0] pmode8  = 2'b00;
    logic       stop2_8 = 1'b0;
    logic       ready8;
    logic       line8;
    logic       busy8;
    logic [2:0] count8;

    uart_tx_fifo #(
        .DATA_BITS(8), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB)
    ) dut8 (
        .clock_out(clk), .nreset(nreset),
        .valid_tx_in(valid8), .data_tx_in(data8), .ready_tx_out(ready8),
        .parity_mode_in(pmode8), .stop2_in(stop2_8),
        .sdata_tx_out(line8), .busy_tx_out(busy8), .fifo_count_out(count8)
    );

    // ---------------- 5-bit channel ----------------
    logic       valid5  = 1'b0;
    logic [4:0] data5   = '0;
    logic [1:0] pmode5  = 2'b00;
    logic       stop2_5 = 1'b0;
    logic       ready5;
    logic       line5;
    logic       busy5;
    logic [2:0] count5;

    uart_tx_fifo #(
        .DATA_BITS(5), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB)
    ) dut5 (
        .clock_out(clk), .nreset(nreset),
        .valid_tx_in(valid5), .data_tx_in(data5), .ready_tx_out(ready5),
        .parity_mode_in(pmode5), .stop2_in(stop2_5),
        .sdata_tx_out(line5), .busy_tx_out(busy5), .fifo_count_out(count5)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of the 8-bit channel ----------------
    // exp_q holds the words the FIFO must contain; line_q holds the expected
    // (line, busy) value of every remaining cycle of the current frame,
    // including the one mandatory idle cycle after the last stop bit.
    typedef struct packed {
        logic line;
        logic busy;
    } cyc_t;

    logic [7:0] exp_q[$];
    cyc_t       line_q[$];
    cyc_t       cur = '{line: 1'b1, busy: 1'b0};

    task automatic add_cycles(input logic v, input int n);
        for (int k = 0; k < n; k++) line_q.push_back('{line: v, busy: 1'b1});
    endtask

    task automatic build_frame(input logic [7:0] w, input logic [1:0] pm, input logic s2);
        add_cycles(1'b0, CPB);
        for (int b = 0; b < 8; b++) add_cycles(w[b], CPB);
        if (pm == 2'b01 || pm == 2'b10) add_cycles((^w) ^ (pm == 2'b10), CPB);
        add_cycles(1'b1, s2 ? 2 * CPB : CPB);
        line_q.push_back('{line: 1'b1, busy: 1'b0});
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge nreset);
            if (!nreset) begin
                exp_q.delete();
                line_q.delete();
                cur = '{line: 1'b1, busy: 1'b0};
            end else begin
                logic take;
                // Acceptance and the pop decision both use the pre-edge count.
                take = valid8 && (exp_q.size() != DEPTH);
                if (line_q.size() == 0 && exp_q.size() != 0)
                    build_frame(exp_q.pop_front(), pmode8, stop2_8);
                if (line_q.size() != 0) cur = line_q.pop_front();
                else                    cur = '{line: 1'b1, busy: 1'b0};
                if (take) exp_q.push_back(data8);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            chk("line",  line8,  cur.line);
            chk("busy",  busy8,  cur.busy);
            chk("count", count8, exp_q.size());
            chk("ready", ready8, exp_q.size() != DEPTH);
        end
    end

    // ---------------- driver tasks (called at a falling edge) ----------------
    task automatic push8(input logic [7:0] w);
        int t;
        t = 0;
        while (!ready8 && t < 1000) begin @(negedge clk); t++; end
        valid8 = 1'b1;
        data8  = w;
        @(negedge clk);
        valid8 = 1'b0;
    endtask

    task automatic push5(input logic [4:0] w);
        valid5 = 1'b1;
        data5  = w;
        @(negedge clk);
        valid5 = 1'b0;
    endtask

    // Records the busy window of one frame: its length in cycles and the line
    // value in the middle of each bit period (index 0 = start bit).
    task automatic capture(input bit sel, output int len, output logic [15:0] mids);
        int t;
        t    = 0;
        len  = 0;
        mids = '0;
        while (((sel ? busy5 : busy8) !== 1'b1) && t < 100) begin @(negedge clk); t++; end
        while (((sel ? busy5 : busy8) === 1'b1) && len < 200) begin
            if ((len % CPB) == (CPB / 2) && (len / CPB) < 16)
                mids[len / CPB] = sel ? line5 : line8;
            len++;
            @(negedge clk);
        end
    endtask

    task automatic wait_drained();
        int t;
        logic done;
        t    = 0;
        done = 1'b0;
        while (!done && t < 2000) begin
            @(negedge clk);
            t++;
            done = (count8 == 3'd0) && !busy8;
        end
        chk("drained", done, 1'b1);
    endtask

    // ---------------- directed and random stimulus ----------------
    int          len, len1, len2;
    logic [15:0] mids, m1, m2;
    logic [7:0]  words[6];

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_line",  line8,  1'b1);
        chk("reset_busy",  busy8,  1'b0);
        chk("reset_count", count8, 3'd0);
        chk("reset_ready", ready8, 1'b1);
        nreset = 1'b1;
        @(negedge clk);

        // 8N1, 0x55: start, 1010_1010 LSB first, stop
        push8(8'h55);
        capture(1'b0, len, mids);
        chk("8n1_len",  len, 40);
        chk("8n1_bits", mids[9:0], 10'h2AA);

        // 0x07 even parity: parity bit 1
        pmode8 = 2'b01;
        push8(8'h07);
        capture(1'b0, len, mids);
        chk("even_len",  len, 44);
        chk("even_bits", mids[10:0], 11'h60E);

        // 0x07 odd parity: parity bit 0
        pmode8 = 2'b10;
        push8(8'h07);
        capture(1'b0, len, mids);
        chk("odd_len",  len, 44);
        chk("odd_bits", mids[10:0], 11'h40E);

        // two stop bits, no parity
        pmode8  = 2'b00;
        stop2_8 = 1'b1;
        push8(8'h07);
        capture(1'b0, len, mids);
        chk("stop2_len",  len, 44);
        chk("stop2_bits", mids[10:0], 11'h60E);
        stop2_8 = 1'b0;

        // 5-bit channel: 0x1F odd parity -> 11111, parity 0, stop
        pmode5 = 2'b10;
        push5(5'h1F);
        capture(1'b1, len, mids);
        chk("d5_len",  len, 32);
        chk("d5_bits", mids[7:0], 8'hBE);
        chk("d5_count", count5, 3'd0);

        // parity enabled mid-frame: frame 1 unaffected, frame 2 carries it
        pmode8 = 2'b00;
        push8(8'hA3);
        push8(8'h3C);
        fork
            capture(1'b0, len1, m1);
            begin
                repeat (12) @(negedge clk);
                pmode8 = 2'b01;
            end
        join
        capture(1'b0, len2, m2);
        chk("cfg_f1_len", len1, 40);
        chk("cfg_f2_len", len2, 44);
        chk("cfg_f2_par_stop", m2[10:9], 2'b10);
        pmode8 = 2'b00;

        // FIFO full: valid held high over six words
        begin
            int   i;
            logic r;
            logic saw_full;
            for (int k = 0; k < 6; k++) words[k] = 8'(17 * (k + 1));
            i        = 0;
            saw_full = 1'b0;
            valid8   = 1'b1;
            data8    = words[0];
            r        = ready8;
            for (int t = 0; t < 600 && i < 6; t++) begin
                @(negedge clk);
                if (r) i++;
                if (count8 == 3'd4 && !ready8) saw_full = 1'b1;
                if (i < 6) begin
                    data8 = words[i];
                    r     = ready8;
                end
            end
            valid8 = 1'b0;
            chk("fill_accepted", i, 6);
            chk("fill_saw_full", saw_full, 1'b1);
        end
        wait_drained();

        // reset during data bit 3 of a frame with two words still queued
        push8(8'h00);
        push8(8'hFF);
        push8(8'h81);
        repeat (16) @(negedge clk);
        chk("pre_reset_line",  line8,  1'b0);
        chk("pre_reset_count", count8, 3'd2);
        #2 nreset = 1'b0;
        #1;
        chk("abort_line",  line8,  1'b1);
        chk("abort_count", count8, 3'd0);
        chk("abort_busy",  busy8,  1'b0);
        @(negedge clk);
        nreset = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_reset_line", line8, 1'b1);
        chk("post_reset_busy", busy8, 1'b0);

        // randomized traffic with configuration changes
        for (int c = 0; c < 2500; c++) begin
            valid8 = ($urandom_range(0, 2) == 0);
            data8  = 8'($urandom);
            if ($urandom_range(0, 15) == 0) pmode8  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) stop2_8 = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        valid8 = 1'b0;
        wait_drained();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
